vga_char_timing: RTL and testbench
==================================

Name: vga_char_timing

Overview:
- Raster timing and character-cell address generator for the 80x30 text display (640x480 @ 60 Hz, 8x16 glyphs).
- Sits directly downstream of the APB character/colour map registers, on their read side.
- Each pixel it issues the character-map / colour-map address and the glyph row/column for the character-generator ROM lookup.
- It delays hSYNC/vSYNC/active by the memory read latency so they stay pixel-aligned with the looked-up glyph data.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 1
- PIPE_LAT, 2, pixel ticks of map+ROM read latency compensated on sync/active outputs; range 0..4

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- en_i  in  1  timing enable; 0 holds the raster in reset state
- pix_tick_o  out  1  1-clock pulse, one per pixel
- char_addr_o  out  12  character/colour map address = row*80 + col (0..2399)
- glyph_x_o  out  3  pixel column inside the glyph (hcount[2:0])
- glyph_y_o  out  4  pixel row inside the glyph (vcount[3:0])
- addr_valid_o  out  1  char_addr_o refers to a visible pixel (undelayed)
- active_o  out  1  visible-area flag, delayed PIPE_LAT pixel ticks
- hSYNC_o  out  1  horizontal sync, active low, delayed PIPE_LAT pixel ticks
- vSYNC_o  out  1  vertical sync, active low, delayed PIPE_LAT pixel ticks
- line_start_o  out  1  1-clock pulse coincident with pix_tick_o when hcount wraps to 0
- frame_start_o  out  1  1-clock pulse coincident with pix_tick_o when hcount and vcount both wrap to 0

Behaviour:
- Reset values:
  - divider, hcount, vcount = 0; all delay stages cleared
  - pix_tick_o, active_o, addr_valid_o, line_start_o, frame_start_o = 0
  - char_addr_o, glyph_x_o, glyph_y_o = 0
  - hSYNC_o = vSYNC_o = 1 (inactive)
- Divider counts 0..CLK_DIV-1. pix_tick_o = 1 in the clock where the divider equals CLK_DIV-1. CLK_DIV=1 gives a tick every clock.
- On each tick:
  - hcount increments and wraps at H_TOTAL-1 (800 by default).
  - On wrap, vcount increments and wraps at V_TOTAL-1 (525).
  - line_start_o and frame_start_o are asserted in the tick clock that performs the wrap.
- Undelayed raster signals (stage 0):
  - active0 = hcount < H_ACTIVE && vcount < V_ACTIVE
  - hs0 = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs0 = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491)
- Address path, registered on each tick from the post-increment counters:
  - char_addr_o = (vcount>>4)*80 + (hcount>>3)
  - Multiply implemented as (r<<6)+(r<<4); no DSP.
  - Outside the active area char_addr_o holds 0 and addr_valid_o = 0.
- Delay path: active/hs/vs pass through a PIPE_LAT-deep shift register advanced only on pix_tick_o. PIPE_LAT=0 drives active0/hs0/vs0 registered with the address.
- Outputs hold between ticks; all are registered.
- en_i = 0:
  - divider, hcount, vcount cleared synchronously; delay stages flushed to inactive (sync=1, active=0)
  - no pix_tick_o or start pulses
  - On en_i rising, the first tick occurs CLK_DIV clocks later, at hcount=0 / vcount=0; frame_start_o is not asserted for that first pixel.
- Deasserting en_i mid-frame aborts the frame with no partial sync pulse left asserted.
- Last visible cell is (639,479) -> char_addr_o = 29*80+79 = 2399; the address never exceeds 2399.
- Asynchronous reset mid-frame returns every output to its reset value immediately.

Test Plan:
- Reset, en_i=1, defaults: pix_tick_o every 4 clocks; 800 ticks between line_start_o pulses; 420000 ticks (1,680,000 clocks) between frame_start_o pulses.
- hSYNC timing, PIPE_LAT=2: hSYNC_o falls exactly 2 ticks after the tick where hcount=656, and stays low for 96 ticks. vSYNC_o is low for exactly 2 lines (490, 491).
- Address sweep: at (h,v)=(0,0) -> addr 0, glyph 0/0; (15,15) -> addr 1, glyph_x 7, glyph_y 15; (8,16) -> addr 81; (639,479) -> addr 2399, addr_valid_o=1; (640,0) -> addr_valid_o=0.
- active_o: exactly 640*480 = 307200 ticks per frame with active_o=1, each delayed 2 ticks from addr_valid_o.
- en_i dropped at vcount=491 (vSYNC_o low): within PIPE_LAT+1 ticks-equivalent clocks hSYNC_o=vSYNC_o=1 and active_o=0. Re-enable: first tick after 4 clocks with addr 0.
- CLK_DIV=1, PIPE_LAT=0: tick every clock; hSYNC_o low from the clock after hcount=656 registers. rstn_i pulsed low mid-line: outputs return to reset values asynchronously and restart from (0,0).

Source files
------------

// File: rtl/vga_char_timing.sv
// -----------------------------------------------------------------------------
// vga_char_timing
//
// Raster timing and character-cell address generator for an 80x30 text
// display (640x480 @ 60 Hz with 8x16 glyphs by default).
//
// A clock divider produces one pixel tick every CLK_DIV system clocks. On every
// tick the horizontal/vertical counters advance. This block then registers:
//   - the character/colour map address, which is row*80 + col for visible
//     pixels and 0 elsewhere,
//   - the glyph column and glyph row used by the character ROM.
// The active, hsync and vsync flags pass through a PIPE_LAT-deep shift
// register. That register advances only on ticks, so the flags line up with
// glyph data returned by the map + ROM reads.
//
// Ports:
//   clk_i          system clock
//   rstn_i         asynchronous active-low reset
//   en_i           timing enable; low holds the raster in its reset state
//   pix_tick_o     one-clock pulse per pixel
//   char_addr_o    character/colour map address (0..2399)
//   glyph_x_o      pixel column inside the glyph (hcount[2:0])
//   glyph_y_o      pixel row inside the glyph (vcount[3:0])
//   addr_valid_o   char_addr_o refers to a visible pixel (undelayed)
//   active_o       visible-area flag, delayed PIPE_LAT ticks
//   hSYNC_o        horizontal sync, active low, delayed PIPE_LAT ticks
//   vSYNC_o        vertical sync, active low, delayed PIPE_LAT ticks
//   line_start_o   tick-coincident pulse when hcount wraps to 0
//   frame_start_o  tick-coincident pulse when hcount and vcount wrap to 0
// -----------------------------------------------------------------------------
module vga_char_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        en_i,
    output logic        pix_tick_o,
    output logic [11:0] char_addr_o,
    output logic [2:0]  glyph_x_o,
    output logic [3:0]  glyph_y_o,
    output logic        addr_valid_o,
    output logic        active_o,
    output logic        hSYNC_o,
    output logic        vSYNC_o,
    output logic        line_start_o,
    output logic        frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Raster state
    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              started_q, started_d;

    // Registered outputs
    logic              tick_q, tick_d;
    logic              line_q, line_d;
    logic              frame_q, frame_d;
    logic [11:0]       addr_q, addr_d;
    logic [2:0]        gx_q, gx_d;
    logic [3:0]        gy_q, gy_d;
    logic [PIPE_LAT:0] act_q, act_d;
    logic [PIPE_LAT:0] hs_q, hs_d;
    logic [PIPE_LAT:0] vs_q, vs_d;

    // Combinational helpers
    logic [HW-1:0]     h_nx_s;
    logic [VW-1:0]     v_nx_s;
    logic              line_wrap_s;
    logic              frame_wrap_s;
    logic              act0_s;
    logic              hs0_s;
    logic              vs0_s;
    logic [11:0]       row_s;
    logic [11:0]       col_s;
    logic [11:0]       addr0_s;

    // Raster position the next tick moves to. The first tick after enable
    // presents (0,0) itself instead of stepping past it.
    always_comb begin
        h_nx_s       = '0;
        v_nx_s       = '0;
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        if (!started_q) begin
            h_nx_s = '0;
            v_nx_s = '0;
        end else if (h_q == H_LAST) begin
            line_wrap_s = 1'b1;
            if (v_q == V_LAST) begin
                v_nx_s       = '0;
                frame_wrap_s = 1'b1;
            end else begin
                v_nx_s = v_q + 1'b1;
            end
        end else begin
            h_nx_s = h_q + 1'b1;
            v_nx_s = v_q;
        end
    end

    // Stage-0 flags and the character address for the upcoming pixel.
    // row*80 is built as row*64 + row*16 so that no multiplier is inferred.
    always_comb begin
        act0_s = (h_nx_s < H_ACT) && (v_nx_s < V_ACT);
        hs0_s  = !((h_nx_s >= H_SS) && (h_nx_s < H_SE));
        vs0_s  = !((v_nx_s >= V_SS) && (v_nx_s < V_SE));
        row_s  = 12'(v_nx_s >> 3'd4);
        col_s  = 12'(h_nx_s >> 3'd3);
        if (act0_s) begin
            addr0_s = (row_s << 4'd6) + (row_s << 4'd4) + col_s;
        end else begin
            addr0_s = 12'd0;
        end
    end

    // Next-state logic. Enable low flushes everything to its idle value.
    // Each tick advances the counters and the delay line. Between ticks
    // every output holds except for the single-clock pulses.
    always_comb begin
        div_d     = div_q;
        h_d       = h_q;
        v_d       = v_q;
        started_d = started_q;
        tick_d    = 1'b0;
        line_d    = 1'b0;
        frame_d   = 1'b0;
        addr_d    = addr_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        act_d     = act_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        if (!en_i) begin
            div_d     = '0;
            h_d       = '0;
            v_d       = '0;
            started_d = 1'b0;
            addr_d    = 12'd0;
            gx_d      = 3'd0;
            gy_d      = 4'd0;
            act_d     = '0;
            hs_d      = '1;
            vs_d      = '1;
        end else if (div_q == DIV_LAST) begin
            div_d     = '0;
            h_d       = h_nx_s;
            v_d       = v_nx_s;
            started_d = 1'b1;
            tick_d    = 1'b1;
            line_d    = line_wrap_s;
            frame_d   = frame_wrap_s;
            addr_d    = addr0_s;
            gx_d      = h_nx_s[2:0];
            gy_d      = v_nx_s[3:0];
            act_d[0]  = act0_s;
            hs_d[0]   = hs0_s;
            vs_d[0]   = vs0_s;
            for (int i = 1; i <= PIPE_LAT; i++) begin
                act_d[i] = act_q[i-1];
                hs_d[i]  = hs_q[i-1];
                vs_d[i]  = vs_q[i-1];
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // State and output registers with asynchronous reset to the idle raster
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            started_q <= 1'b0;
            tick_q    <= 1'b0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            addr_q    <= 12'd0;
            gx_q      <= 3'd0;
            gy_q      <= 4'd0;
            act_q     <= '0;
            hs_q      <= '1;
            vs_q      <= '1;
        end else begin
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            started_q <= started_d;
            tick_q    <= tick_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
            addr_q    <= addr_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            act_q     <= act_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    assign pix_tick_o    = tick_q;
    assign char_addr_o   = addr_q;
    assign glyph_x_o     = gx_q;
    assign glyph_y_o     = gy_q;
    assign addr_valid_o  = act_q[0];
    assign active_o      = act_q[PIPE_LAT];
    assign hSYNC_o       = hs_q[PIPE_LAT];
    assign vSYNC_o       = vs_q[PIPE_LAT];
    assign line_start_o  = line_q;
    assign frame_start_o = frame_q;

endmodule

// File: tb/tb_vga_char_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_char_timing
//
// Bench for vga_char_timing with three instances:
//   a: default geometry, CLK_DIV=4, PIPE_LAT=2
//   b: default geometry, CLK_DIV=1, PIPE_LAT=0
//   c: 48x38 reduced geometry, CLK_DIV=4, PIPE_LAT=2, so that whole frames fit
//
// Outputs are predicted from the number of enabled clocks since the last
// reset or enable drop. That count gives the pixel index, and the pixel index
// gives the raster position by plain division.
// -----------------------------------------------------------------------------
module tb_vga_char_timing;

    typedef struct packed {
        logic        tick;
        logic [11:0] addr;
        logic [2:0]  gx;
        logic [3:0]  gy;
        logic        valid;
        logic        active;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    localparam obs_t RESET_OBS = '{tick: 1'b0, addr: 12'd0, gx: 3'd0, gy: 4'd0,
                                   valid: 1'b0, active: 1'b0, hs: 1'b1, vs: 1'b1,
                                   ls: 1'b0, fs: 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a = 1'b0, rstn_b = 1'b0, rstn_c = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;

    logic pt_a, av_a, ac_a, hs_a, vs_a, ls_a, fs_a;
    logic pt_b, av_b, ac_b, hs_b, vs_b, ls_b, fs_b;
    logic pt_c, av_c, ac_c, hs_c, vs_c, ls_c, fs_c;
    logic [11:0] ad_a, ad_b, ad_c;
    logic [2:0]  gx_a, gx_b, gx_c;
    logic [3:0]  gy_a, gy_b, gy_c;
    obs_t obs_a, obs_b, obs_c;

    assign obs_a = {pt_a, ad_a, gx_a, gy_a, av_a, ac_a, hs_a, vs_a, ls_a, fs_a};
    assign obs_b = {pt_b, ad_b, gx_b, gy_b, av_b, ac_b, hs_b, vs_b, ls_b, fs_b};
    assign obs_c = {pt_c, ad_c, gx_c, gy_c, av_c, ac_c, hs_c, vs_c, ls_c, fs_c};

    vga_char_timing #(.CLK_DIV(4), .PIPE_LAT(2)) dut_a (
        .clk_i(clk), .rstn_i(rstn_a), .en_i(en_a), .pix_tick_o(pt_a),
        .char_addr_o(ad_a), .glyph_x_o(gx_a), .glyph_y_o(gy_a),
        .addr_valid_o(av_a), .active_o(ac_a), .hSYNC_o(hs_a), .vSYNC_o(vs_a),
        .line_start_o(ls_a), .frame_start_o(fs_a));

    vga_char_timing #(.CLK_DIV(1), .PIPE_LAT(0)) dut_b (
        .clk_i(clk), .rstn_i(rstn_b), .en_i(en_b), .pix_tick_o(pt_b),
        .char_addr_o(ad_b), .glyph_x_o(gx_b), .glyph_y_o(gy_b),
        .addr_valid_o(av_b), .active_o(ac_b), .hSYNC_o(hs_b), .vSYNC_o(vs_b),
        .line_start_o(ls_b), .frame_start_o(fs_b));

    vga_char_timing #(.H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
                      .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2),
                      .CLK_DIV(4), .PIPE_LAT(2)) dut_c (
        .clk_i(clk), .rstn_i(rstn_c), .en_i(en_c), .pix_tick_o(pt_c),
        .char_addr_o(ad_c), .glyph_x_o(gx_c), .glyph_y_o(gy_c),
        .addr_valid_o(av_c), .active_o(ac_c), .hSYNC_o(hs_c), .vSYNC_o(vs_c),
        .line_start_o(ls_c), .frame_start_o(fs_c));

    int n_checks = 0;
    int n_pass   = 0;

    // Enabled clock edges since the last reset or enable drop, one per DUT
    int ka = 0, kb = 0, kc = 0;

    always @(posedge clk or negedge rstn_a)
        if (!rstn_a) ka <= 0; else if (en_a) ka <= ka + 1; else ka <= 0;
    always @(posedge clk or negedge rstn_b)
        if (!rstn_b) kb <= 0; else if (en_b) kb <= kb + 1; else kb <= 0;
    always @(posedge clk or negedge rstn_c)
        if (!rstn_c) kc <= 0; else if (en_c) kc <= kc + 1; else kc <= 0;

    // Expected outputs after k enabled clocks. Tick n (n = k/cd) shows pixel
    // p = n-1. The delayed flags show pixel p-pl.
    function automatic obs_t model(input int k, input int cd, input int pl,
                                   input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp);
        obs_t e;
        int ht, vt, p, h, v, q, hq, vq;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        e  = RESET_OBS;
        if (k >= cd) begin
            p       = k / cd - 1;
            h       = p % ht;
            v       = (p / ht) % vt;
            e.tick  = (k % cd == 0);
            e.gx    = 3'(h % 8);
            e.gy    = 4'(v % 16);
            e.valid = (h < ha) && (v < va);
            e.addr  = e.valid ? 12'((v / 16) * 80 + h / 8) : 12'd0;
            e.ls    = e.tick && (p > 0) && (h == 0);
            e.fs    = e.ls && (v == 0);
            q = p - pl;
            if (q >= 0) begin
                hq       = q % ht;
                vq       = (q / ht) % vt;
                e.active = (hq < ha) && (vq < va);
                e.hs     = !((hq >= ha + hfp) && (hq < ha + hfp + hsw));
                e.vs     = !((vq >= va + vfp) && (vq < va + vfp + vsw));
            end
        end
        return e;
    endfunction

    function automatic obs_t model_a(input int k);
        return model(k, 4, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic obs_t model_b(input int k);
        return model(k, 1, 0, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic obs_t model_c(input int k);
        return model(k, 4, 2, 32, 4, 8, 4, 32, 2, 2, 2);
    endfunction

    task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got=%h expected=%h", nm, $time, got, exp);
    endtask

    task automatic check_lit(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @%0t: got=%0d expected=%0d", nm, $time, got, exp);
    endtask

    // Every clock, each DUT is compared with the model
    always @(negedge clk) begin
        check_obs("cmp_a", obs_a, model_a(ka));
        check_obs("cmp_b", obs_b, model_b(kb));
        check_obs("cmp_c", obs_c, model_c(kc));
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    int   tick_n, hs_low, first_fall, act_cnt, vs_cnt, found;
    int   ls_q[$];
    int   fs_q[$];
    obs_t e;

    initial begin
        // Pin the model with hand-computed points
        e = model_a(4);
        check_lit("model_first_tick", int'(e.tick), 1);
        check_lit("model_first_addr", int'(e.addr), 0);
        e = model_b(15 * 800 + 15 + 1);
        check_lit("model_addr_15_15", int'(e.addr), 1);
        check_lit("model_gx_15_15", int'(e.gx), 7);
        check_lit("model_gy_15_15", int'(e.gy), 15);
        e = model_b(479 * 800 + 639 + 1);
        check_lit("model_addr_last", int'(e.addr), 2399);
        check_lit("model_valid_last", int'(e.valid), 1);
        e = model_b(640 + 1);
        check_lit("model_valid_640", int'(e.valid), 0);
        e = model_a(659 * 4);
        check_lit("model_hs_fall", int'(e.hs), 0);
        e = model_a(658 * 4);
        check_lit("model_hs_before", int'(e.hs), 1);
        e = model_c(1825 * 4);
        check_lit("model_fs_small", int'(e.fs), 1);

        repeat (3) @(negedge clk);
        check_obs("reset_a", obs_a, RESET_OBS);
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;

        // Instance a: tick spacing, line period, hsync placement
        @(negedge clk);
        en_a = 1'b1;
        tick_n = 0; hs_low = 0; first_fall = -1;
        for (int c = 0; c < 7400; c++) begin
            @(negedge clk);
            if (c == 2) check_lit("a_no_tick_yet", int'(pt_a), 0);
            if (c == 3) begin
                check_lit("a_first_tick", int'(pt_a), 1);
                check_lit("a_first_addr", int'(ad_a), 0);
                check_lit("a_first_fs", int'(fs_a), 0);
            end
            if (pt_a) begin
                tick_n++;
                if (ls_a) ls_q.push_back(tick_n);
                if (!hs_a && first_fall < 0) first_fall = tick_n;
                if (!hs_a && ls_q.size() == 1) hs_low++;
            end
        end
        check_lit("a_tick_count", tick_n, 1850);
        check_lit("a_first_line_start", (ls_q.size() >= 1) ? ls_q[0] : -1, 801);
        check_lit("a_line_period", (ls_q.size() >= 2) ? ls_q[1] - ls_q[0] : -1, 800);
        check_lit("a_hsync_fall_tick", first_fall, 659);
        check_lit("a_hsync_width", hs_low, 96);
        en_a = 1'b0;
        @(negedge clk);
        check_lit("a_off_hs", int'(hs_a), 1);
        check_lit("a_off_active", int'(ac_a), 0);

        // Instance b: tick every clock, address sweep, async reset mid-line
        en_b = 1'b1;
        for (int c = 0; c < 13620; c++) begin
            @(negedge clk);
            if (c == 0)     check_lit("b_first_tick", int'(pt_b), 1);
            if (c == 1)     check_lit("b_second_tick", int'(pt_b), 1);
            if (c == 639)   check_lit("b_addr_639", int'(ad_b), 79);
            if (c == 640)   check_lit("b_valid_640", int'(av_b), 0);
            if (c == 655)   check_lit("b_hs_655", int'(hs_b), 1);
            if (c == 656)   check_lit("b_hs_656", int'(hs_b), 0);
            if (c == 800)   check_lit("b_line_start", int'(ls_b), 1);
            if (c == 12015) begin
                check_lit("b_addr_15_15", int'(ad_b), 1);
                check_lit("b_gx_15_15", int'(gx_b), 7);
                check_lit("b_gy_15_15", int'(gy_b), 15);
            end
            if (c == 12808) check_lit("b_addr_8_16", int'(ad_b), 81);
        end
        repeat ($urandom_range(50, 700)) @(negedge clk);
        #3 rstn_b = 1'b0;
        #1 check_obs("b_async_reset", obs_b, RESET_OBS);
        @(negedge clk);
        rstn_b = 1'b1;
        @(negedge clk);
        check_lit("b_restart_tick", int'(pt_b), 1);
        check_lit("b_restart_addr", int'(ad_b), 0);
        check_lit("b_restart_fs", int'(fs_b), 0);
        repeat (900) @(negedge clk);
        en_b = 1'b0;

        // Instance c: whole frames, vsync width, active count, enable drop
        @(negedge clk);
        en_c = 1'b1;
        tick_n = 0; act_cnt = 0; vs_cnt = 0;
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            if (pt_c) begin
                tick_n++;
                if (fs_c) fs_q.push_back(tick_n);
                if (fs_q.size() == 1) begin
                    if (ac_c) act_cnt++;
                    if (!vs_c) vs_cnt++;
                end
            end
        end
        check_lit("c_first_frame_start", (fs_q.size() >= 1) ? fs_q[0] : -1, 1825);
        check_lit("c_frame_period", (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1, 1824);
        check_lit("c_active_per_frame", act_cnt, 1024);
        check_lit("c_vsync_low_ticks", vs_cnt, 96);

        found = 0;
        for (int c = 0; c < 15000 && found == 0; c++) begin
            @(negedge clk);
            if (!vs_c) found = 1;
        end
        check_lit("c_vsync_seen", found, 1);
        en_c = 1'b0;
        @(negedge clk);
        check_lit("c_drop_hs", int'(hs_c), 1);
        check_lit("c_drop_vs", int'(vs_c), 1);
        check_lit("c_drop_active", int'(ac_c), 0);
        en_c = 1'b1;
        repeat (3) @(negedge clk);
        check_lit("c_reen_no_tick", int'(pt_c), 0);
        @(negedge clk);
        check_lit("c_reen_tick", int'(pt_c), 1);
        check_lit("c_reen_addr", int'(ad_c), 0);
        check_lit("c_reen_fs", int'(fs_c), 0);

        // Random enable drops and reset pulses, checked by the compare process
        for (int it = 0; it < 12; it++) begin
            en_c = 1'b1;
            repeat ($urandom_range(1, 2000)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                #3 rstn_c = 1'b0;
                #1 check_obs("c_rand_reset", obs_c, RESET_OBS);
                @(negedge clk);
                rstn_c = 1'b1;
            end else begin
                en_c = 1'b0;
                repeat ($urandom_range(1, 8)) @(negedge clk);
            end
        end
        en_c = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
